// File: rtl/entropy_fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter that shares one entropy FIFO write port between NumReq producers.
// Optional saturating violation counter enabled by defining ENTROPY_FIFO_ARB_ERR_CNT_EN.
module entropy_fifo_wr_arbiter #(
    parameter int NumReq = 4,
    parameter int Width  = 32,
    localparam int IdxW  = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq-1:0]       req_last_i,
    input  logic [NumReq*Width-1:0] req_data_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic                    fifo_wvalid_o,
    output logic [Width-1:0]        fifo_wdata_o,
    input  logic                    fifo_wready_i,
    input  logic                    fifo_full_i,
    output logic [IdxW-1:0]         grant_idx_o,
    output logic                    locked_o,
    output logic                    write_err_o,
    output logic [15:0]             err_cnt_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [IdxW-1:0]  r_ptr;
    logic [IdxW-1:0]  r_grantIdx;
    logic             r_wvalid;
    logic [Width-1:0] r_wdata;
    logic             r_violQ;

    logic [IdxW-1:0]  w_pickIdx;
    logic             w_pickValid;
    int               w_scan;
    logic             w_space;
    logic [IdxW-1:0]  w_gIdx;
    logic             w_gOk;
    logic             w_accept;
    logic             w_last;
    logic [IdxW-1:0]  w_nextPtr;
    logic             w_violD;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_pickValid = 1'b0;
        w_pickIdx   = '0;
        w_scan      = 0;
        for (int k = 0; k < NumReq; k++) begin
            w_scan = (int'(r_ptr) + k) % NumReq;
            if (!w_pickValid && req_valid_i[w_scan]) begin
                w_pickValid = 1'b1;
                w_pickIdx   = IdxW'(w_scan);
            end
        end
    end

    assign w_space = !r_wvalid || fifo_wready_i;
    assign w_gIdx  = (r_state == LOCKED) ? r_grantIdx : w_pickIdx;
    assign w_gOk   = (r_state == LOCKED) || w_pickValid;

    always_comb begin
        req_ready_o = '0;
        if (enable_i && w_space && w_gOk) begin
            req_ready_o[w_gIdx] = 1'b1;
        end
    end

    assign w_accept  = req_valid_i[w_gIdx] && req_ready_o[w_gIdx];
    assign w_last    = req_last_i[w_gIdx];
    assign w_nextPtr = (int'(w_gIdx) == NumReq - 1) ? '0 : w_gIdx + IdxW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grantIdx <= '0;
            r_wvalid   <= 1'b0;
            r_wdata    <= '0;
        end else begin
            if (w_accept) begin
                r_wvalid   <= 1'b1;
                r_wdata    <= req_data_i[w_gIdx*Width +: Width];
                r_grantIdx <= w_gIdx;
                if (w_last) begin
                    r_state <= IDLE;
                    r_ptr   <= w_nextPtr;
                end else begin
                    r_state <= LOCKED;
                end
            end else if (fifo_wready_i) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    // A write accepted while the FIFO reports full; only the first cycle of a run is flagged.
    assign w_violD = r_wvalid && fifo_wready_i && fifo_full_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_violQ <= 1'b0;
        end else begin
            r_violQ <= w_violD;
        end
    end

    assign write_err_o   = w_violD && !r_violQ;
    assign fifo_wvalid_o = r_wvalid;
    assign fifo_wdata_o  = r_wdata;
    assign grant_idx_o   = r_grantIdx;
    assign locked_o      = (r_state == LOCKED);

`ifdef ENTROPY_FIFO_ARB_ERR_CNT_EN
    logic [15:0] r_errCnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_errCnt <= '0;
        end else if (write_err_o && (r_errCnt != 16'hFFFF)) begin
            r_errCnt <= r_errCnt + 16'd1;
        end
    end

    assign err_cnt_o = r_errCnt;
`else
    assign err_cnt_o = 16'h0;
`endif

endmodule
